// File: rtl/y_tile_line_packer.sv
// y_tile_line_packer: packs Q8.8 gate-output tiles into DATA_W-bit lines,
// queues them in a line FIFO and streams them out with TLAST/TUSER.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   clr                sync clear of packing state and FIFO
//   y_axis_*           tile input stream (TILE_SIZE lanes of DATA_WIDTH)
//   m_axis_*           line output stream (TUSER = line index in vector)
//   vec_done           one-cycle pulse after the last line of a vector leaves
module y_tile_line_packer #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DATA_W     = 256,
    parameter int D          = 256,
    parameter int FIFO_DEPTH = 4,
    localparam int TPL    = DATA_W / (TILE_SIZE * DATA_WIDTH),
    localparam int LPV    = D * DATA_WIDTH / DATA_W,
    localparam int LIDX_W = $clog2(LPV)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         y_axis_TVALID,
    output logic                         y_axis_TREADY,
    input  logic signed [DATA_WIDTH-1:0] y_axis_TDATA [TILE_SIZE],
    output logic                         m_axis_TVALID,
    input  logic                         m_axis_TREADY,
    output logic [DATA_W-1:0]            m_axis_TDATA,
    output logic                         m_axis_TLAST,
    output logic [LIDX_W-1:0]            m_axis_TUSER,
    output logic                         vec_done
);

    localparam int TW   = TILE_SIZE * DATA_WIDTH;
    localparam int TC_W = (TPL > 1) ? $clog2(TPL) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [TC_W-1:0]   TC_LAST  = TC_W'(TPL - 1);
    localparam logic [LIDX_W-1:0] LC_LAST  = LIDX_W'(LPV - 1);
    localparam logic [CW-1:0]     CNT_FULL = CW'(FIFO_DEPTH);

    logic                ready_en;
    logic [TC_W-1:0]     tcnt;
    logic [LIDX_W-1:0]   lcnt;
    logic [DATA_W-1:0]   asm_q;
    logic [TW-1:0]       tile;
    logic [DATA_W-1:0]   line;

    logic [DATA_W-1:0]   mem_data [FIFO_DEPTH];
    logic [LIDX_W-1:0]   mem_user [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [CW-1:0]       count;

    logic in_fire;
    logic out_fire;
    logic tile_last;
    logic push;
    logic full;

    assign tile_last = (tcnt == TC_LAST);
    assign full      = (count == CNT_FULL);

    // Only a line-completing tile needs a free FIFO slot.
    assign y_axis_TREADY = ready_en & (~tile_last | ~full);
    assign in_fire  = y_axis_TVALID & y_axis_TREADY;
    assign out_fire = m_axis_TVALID & m_axis_TREADY;
    assign push     = in_fire & tile_last;

    assign m_axis_TVALID = (count != '0);
    assign m_axis_TDATA  = mem_data[rptr];
    assign m_axis_TLAST  = mem_last[rptr];
    assign m_axis_TUSER  = mem_user[rptr];

    always_comb begin
        tile = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            tile[i*DATA_WIDTH +: DATA_WIDTH] = y_axis_TDATA[i];
        end
    end

    // Final tile goes straight into the line, bypassing asm_q.
    always_comb begin
        line = asm_q;
        line[(TPL-1)*TW +: TW] = tile;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt  <= '0;
            lcnt  <= '0;
            asm_q <= '0;
        end else if (clr) begin
            tcnt <= '0;
            lcnt <= '0;
        end else if (in_fire) begin
            if (tile_last) begin
                tcnt <= '0;
                lcnt <= (lcnt == LC_LAST) ? '0 : lcnt + 1'b1;
            end else begin
                asm_q[int'(tcnt)*TW +: TW] <= tile;
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_user[i] <= '0;
            end
            mem_last <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            vec_done <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            vec_done <= 1'b0;
        end else begin
            vec_done <= out_fire & m_axis_TLAST;
            if (push) begin
                mem_data[wptr] <= line;
                mem_user[wptr] <= lcnt;
                mem_last[wptr] <= (lcnt == LC_LAST);
                wptr           <= wptr + 1'b1;
            end
            if (out_fire) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !out_fire) begin
                count <= count + 1'b1;
            end else if (!push && out_fire) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_y_tile_line_packer.sv
// tb_y_tile_line_packer: scoreboard bench for y_tile_line_packer.
// Reference model treats input as a flat word stream cut into lines.
module tb_y_tile_line_packer;

    localparam int WPL = 16;
    localparam int LPV = 16;

    typedef struct {
        logic [255:0] data;
        logic         last;
        logic [3:0]   user;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic y_valid = 1'b0;
    logic y_ready;
    logic signed [15:0] tdata [4];
    logic m_valid;
    logic m_ready = 1'b0;
    logic [255:0] m_data;
    logic m_last;
    logic [3:0] m_user;
    logic vec_done;

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int lasts = 0;
    int vds = 0;
    int acc = 0;
    int tile_ctr = 0;
    int mlcnt = 0;
    bit rnd = 0;

    logic [15:0] pend [$];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    y_tile_line_packer dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .y_axis_TVALID(y_valid),
        .y_axis_TREADY(y_ready),
        .y_axis_TDATA(tdata),
        .m_axis_TVALID(m_valid),
        .m_axis_TREADY(m_ready),
        .m_axis_TDATA(m_data),
        .m_axis_TLAST(m_last),
        .m_axis_TUSER(m_user),
        .vec_done(vec_done)
    );

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flush_model();
        pend.delete();
        exp_q.delete();
        mlcnt = 0;
    endtask

    task automatic accept();
        exp_t e;
        for (int i = 0; i < 4; i++) pend.push_back(tdata[i]);
        tile_ctr++;
        acc++;
        if (pend.size() == WPL) begin
            e.data = '0;
            for (int w = 0; w < WPL; w++) e.data[w*16 +: 16] = pend[w];
            e.last = (mlcnt == LPV - 1);
            e.user = 4'(mlcnt);
            exp_q.push_back(e);
            mlcnt = (mlcnt + 1) % LPV;
            pend.delete();
        end
    endtask

    task automatic drive(input bit v, input bit r);
        @(negedge clk);
        y_valid = v;
        m_ready = r;
        for (int i = 0; i < 4; i++)
            tdata[i] = rnd ? 16'($urandom) : 16'(tile_ctr * 4 + i + 1);
        #1;
        if (y_valid && y_ready) accept();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            drive(0, 1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (3) drive(0, 1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        y_valid = 1'b0;
        m_ready = 1'b0;
        flush_model();
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_tvalid", m_valid, 0);
        chk("clr_vec_done", vec_done, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_release_0", y_ready, 0);
        @(negedge clk);
        #1;
        chk("rdy_release_1", y_ready, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_tready", y_ready, 0);
        chk("rst_tvalid", m_valid, 0);
        chk("rst_tdata", m_data, 0);
        chk("rst_tlast", m_last, 0);
        chk("rst_tuser", m_user, 0);
        chk("rst_vec_done", vec_done, 0);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_line: got user %0d expected none",
                             m_user);
                end else begin
                    e = exp_q.pop_front();
                    chk("line_data", m_data, e.data);
                    chk("line_last", m_last, e.last);
                    chk("line_user", m_user, e.user);
                end
                pops++;
                if (m_last) lasts++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (vec_done === 1'b1) vds++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, p0, l0, v0, nrdy, n;
        logic [255:0] sl;

        for (int i = 0; i < 4; i++) tdata[i] = '0;
        #2;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        release_reset();

        // Single line with latency check.
        tile_ctr = 0;
        p0 = pops;
        for (int t = 0; t < 4; t++) drive(1, 1);
        chk("single_tvalid_pre", m_valid, 0);
        drive(0, 1);
        sl = '0;
        for (int w = 0; w < 16; w++) sl[w*16 +: 16] = 16'(w + 1);
        chk("single_tvalid", m_valid, 1);
        chk("single_data", m_data, sl);
        chk("single_user", m_user, 0);
        chk("single_last", m_last, 0);
        drain();
        chk("single_pops", pops - p0, 1);

        // Full vector back-to-back.
        do_clr();
        tile_ctr = 0;
        p0 = pops; l0 = lasts; v0 = vds; a0 = acc;
        nrdy = 0;
        for (int t = 0; t < 64; t++) begin
            drive(1, 1);
            if (!y_ready) nrdy++;
        end
        drain();
        chk("full_tready", nrdy, 0);
        chk("full_acc", acc - a0, 64);
        chk("full_pops", pops - p0, 16);
        chk("full_tlast", lasts - l0, 1);
        chk("full_vec_done", vds - v0, 1);

        // Back-pressure: 4 lines + 3 tiles then stall.
        tile_ctr = 0;
        p0 = pops; a0 = acc;
        for (int c = 0; c < 30; c++) drive(1, 0);
        chk("bp_accepted", acc - a0, 19);
        chk("bp_tready", y_ready, 0);
        chk("bp_tvalid", m_valid, 1);
        n = 0;
        while (acc - a0 < 24 && n < 60) begin
            drive(1, 1);
            n++;
        end
        chk("bp_all_in", acc - a0, 24);
        drain();
        chk("bp_pops", pops - p0, 6);

        // Random stalls over 3 vectors.
        do_clr();
        rnd = 1;
        l0 = lasts; v0 = vds; a0 = acc;
        n = 0;
        while (acc - a0 < 192 && n < 3000) begin
            @(negedge clk);
            y_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 4; i++) tdata[i] = 16'($urandom);
            #1;
            if (y_valid && y_ready) accept();
            n++;
        end
        chk("rnd_acc", acc - a0, 192);
        drain();
        chk("rnd_tlast", lasts - l0, 3);
        chk("rnd_vec_done", vds - v0, 3);
        rnd = 0;

        // clr mid-line with a queued line.
        do_clr();
        tile_ctr = 0;
        for (int t = 0; t < 6; t++) drive(1, 0);
        chk("clr_pre_tvalid", m_valid, 1);
        do_clr();
        tile_ctr = 0;
        for (int t = 0; t < 4; t++) drive(1, 1);
        drive(0, 1);
        chk("clr_post_tvalid", m_valid, 1);
        chk("clr_post_user", m_user, 0);
        drain();

        // Reset mid-vector.
        do_clr();
        rnd = 1;
        a0 = acc;
        n = 0;
        while (acc - a0 < 37 && n < 100) begin
            drive(1, 1);
            n++;
        end
        @(negedge clk);
        y_valid = 1'b0;
        m_ready = 1'b0;
        rst_n = 1'b0;
        flush_model();
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        release_reset();
        l0 = lasts; v0 = vds; p0 = pops;
        for (int t = 0; t < 64; t++) drive(1, 1);
        drain();
        chk("rst_vec_pops", pops - p0, 16);
        chk("rst_vec_tlast", lasts - l0, 1);
        chk("rst_vec_done", vds - v0, 1);

        chk("final_scoreboard", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/y_tile_line_packer.md
# y_tile_line_packer

Downstream consumer of the gated output stream (y = s ⊙ g, Q8.8, TILE_SIZE lanes per beat) produced by the mac→bias→sigmoid→EW→gate path. Packs consecutive y tiles into DATA_W-bit lines, matching the WBUF/XT line width, and buffers them in a small line FIFO. Emits them on an AXI-Stream-style master with TLAST marking the final line of each D-element vector. Decouples the gate stage from write-back back-pressure.

## Interface
- TILE_SIZE, 4: lanes per input beat
- DATA_WIDTH, 16: bits per lane (Q8.8, passed through unmodified)
- DATA_W, 256: output line width; must be a multiple of TILE_SIZE*DATA_WIDTH
- D, 256: elements per vector; D*DATA_WIDTH must be a multiple of DATA_W
- FIFO_DEPTH, 4: line FIFO entries, power of two, ≥2
- Derived: TPL = DATA_W/(TILE_SIZE*DATA_WIDTH) (4); LPV = D*DATA_WIDTH/DATA_W (16); LIDX_W = $clog2(LPV)

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of packing state and FIFO
- y_axis_TVALID  in  1  input tile valid
- y_axis_TREADY  out  1  input tile ready
- y_axis_TDATA  in  signed [DATA_WIDTH-1:0] x [TILE_SIZE-1:0]  input tile lanes
- m_axis_TVALID  out  1  output line valid
- m_axis_TREADY  in  1  output line ready
- m_axis_TDATA  out  DATA_W  packed line
- m_axis_TLAST  out  1  line is line LPV-1 of a vector
- m_axis_TUSER  out  LIDX_W  line index within vector (0..LPV-1)
- vec_done  out  1  one-cycle pulse when a TLAST line fires on the master side

## Operation
- Fires: in_fire = y_axis_TVALID & y_axis_TREADY; out_fire = m_axis_TVALID & m_axis_TREADY.
- Assembly register asm[DATA_W-1:0], tile counter tcnt (0..TPL-1), line counter lcnt (0..LPV-1).
- On in_fire, lane i of tile k = tcnt goes to bits [(k*TILE_SIZE+i)*DATA_WIDTH +: DATA_WIDTH]; the lowest address lands in the LSBs, matching XT/WBUF line packing.
- tcnt < TPL-1: write tile into asm, tcnt++.
- tcnt == TPL-1: push {current tile, asm lower bits} as one line into the FIFO together with TLAST = (lcnt == LPV-1) and TUSER = lcnt. Then tcnt←0 and lcnt←(lcnt == LPV-1 ? 0 : lcnt+1). asm contents after a push are don't-care.
- y_axis_TREADY = ready_en & ((tcnt != TPL-1) | (fifo_count < FIFO_DEPTH)). It is driven from registered state only; there is no combinational path from m_axis_TREADY.
- ready_en is a flop: reset 0, set to 1 on the first edge after rst_n deasserts.
- FIFO: m_axis_* is driven from the head entry. m_axis_TVALID = (fifo_count != 0).
  - Simultaneous push and pop on a full FIFO is not possible, because TREADY gating blocks the push.
  - Simultaneous push and pop at any other count leaves the count unchanged and is required to work.
- vec_done is registered: it pulses the cycle after an out_fire with TLAST = 1.
- clr (has priority over in_fire and out_fire): tcnt, lcnt and fifo_count go to 0 and vec_done goes to 0. Any partial line and all queued lines are discarded. m_axis_TVALID drops on the next cycle.
- Data is bit-exact; no arithmetic and no saturation.

## Timing
- Reset values: y_axis_TREADY 0, m_axis_TVALID 0, m_axis_TDATA 0, m_axis_TLAST 0, m_axis_TUSER 0, vec_done 0, all counters 0.
- Latency: if the TPL-th tile fires at edge N, m_axis_TVALID is high in the cycle after N, provided the FIFO was empty.
- Throughput: 1 tile/cycle sustained while m_axis_TREADY = 1. One line is produced per TPL cycles.
- m_axis_TDATA/TLAST/TUSER are stable while TVALID = 1 and TREADY = 0.
- Back-pressure: with the FIFO full, the input stalls only on a line-completing tile. Tiles 0..TPL-2 of the next line are still accepted.
- Counters wrap: lcnt returns from LPV-1 to 0 with no idle cycle. Consecutive vectors stream back-to-back.
- rst_n asserted mid-line or mid-vector: all state clears asynchronously. The partial line is lost, and after reset the first tile is tile 0, line 0.

## Test plan
- Single line: 4 tiles with lane value v = 4*t+i+1 (t=0..3, i=0..3), m_axis_TREADY=1 → one line with 16-bit word w = w+1 (w=0..15), TUSER=0, TLAST=0, TVALID one cycle after the 4th fire.
- Full vector: 64 back-to-back tiles → 16 lines with TUSER 0..15; only line 15 has TLAST=1; vec_done pulses once; y_axis_TREADY stays 1 throughout.
- Back-pressure: m_axis_TREADY=0 while 24 tiles are offered → FIFO holds 4 lines, 3 further tiles are accepted, and TREADY=0 on the 4th. Releasing m_axis_TREADY drains 6 lines in order with data intact.
- Random stalls: random TVALID/TREADY over 3 vectors → output word sequence equals the input lane sequence exactly; 3 TLASTs and 3 vec_done pulses.
- clr mid-line: 2 tiles accepted, 1 line queued, then clr → TVALID=0 next cycle; the next 4 tiles form a line with TUSER=0.
- Reset mid-vector: rst_n low after 37 tiles → all outputs return to reset values; y_axis_TREADY=0 in reset, 1 one cycle after release; a fresh vector produces TUSER starting at 0.
